// File: rtl/lsm_regression_scheduler.sv
// lsm_regression_scheduler
//   Per-exercise-date sequencer for the 3x3 LSM regression solver. Streams path
//   samples, accumulates the normal-equation sums for basis [1, s, s^2] over the
//   in-the-money paths, fires the solver and returns beta on a valid/ready port.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin a batch (honoured in IDLE only)
//   s_valid/s_ready        sample handshake; s_ready high only while accumulating
//   s_price, s_payoff      signed Q(16).(WIDTH-16) price and discounted cashflow
//   s_itm, s_last          in-the-money flag, last sample of the batch
//   reg_start              one-cycle solver start pulse
//   reg_A_flat, reg_B_flat X^T X (row-major) and X^T y; element k at [k*WIDTH +: WIDTH]
//   reg_done, reg_beta     solver completion pulse and its result
//   beta_valid/beta_ready  result handshake
//   beta_out, beta_err     [b0,b1,b2] (b0 in LSBs); 00 ok, 01 degenerate, 10 timeout
//   itm_count              ITM samples accumulated in current/last batch
//   busy                   high whenever not IDLE
module lsm_regression_scheduler #(
  parameter int WIDTH          = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [WIDTH-1:0]     s_price,
  input  logic signed [WIDTH-1:0]     s_payoff,
  input  logic                        s_itm,
  input  logic                        s_last,
  output logic                        reg_start,
  output logic        [9*WIDTH-1:0]   reg_A_flat,
  output logic        [3*WIDTH-1:0]   reg_B_flat,
  input  logic                        reg_done,
  input  logic        [3*WIDTH-1:0]   reg_beta,
  output logic                        beta_valid,
  input  logic                        beta_ready,
  output logic        [3*WIDTH-1:0]   beta_out,
  output logic        [1:0]           beta_err,
  output logic        [CNT_WIDTH-1:0] itm_count,
  output logic                        busy
);

  localparam int QFRAC = WIDTH - 16;
  localparam int PW    = 2 * WIDTH;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW    = (CNT_WIDTH + QFRAC > WIDTH) ? (CNT_WIDTH + QFRAC + 1) : (WIDTH + 1);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_DRAIN, S_SOLVE, S_WAIT, S_OUTPUT
  } state_t;

  // Clamp a full-width product (already rescaled) into the WIDTH signed range.
  function automatic logic signed [WIDTH-1:0] f_sat_prod(input logic signed [PW-1:0] v);
    logic [WIDTH:0] hi;
    hi = v[PW-1:WIDTH-1];
    if (hi == '0 || hi == '1) f_sat_prod = v[WIDTH-1:0];
    else if (v[PW-1])         f_sat_prod = SMIN;
    else                      f_sat_prod = SMAX;
  endfunction

  function automatic logic signed [WIDTH-1:0] f_mul(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    p = p >>> QFRAC;
    f_mul = f_sat_prod(p);
  endfunction

  function automatic logic signed [WIDTH-1:0] f_add_sat(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    if (s[WIDTH] != s[WIDTH-1]) f_add_sat = s[WIDTH] ? SMIN : SMAX;
    else                        f_add_sat = s[WIDTH-1:0];
  endfunction

  state_t                  r_state, w_next;
  logic [TW-1:0]           r_cnt;
  logic                    w_take, w_done_hit, w_timeout_hit, w_degen_hit, w_enter_solve;
  logic [CNT_WIDTH-1:0]    r_itm_count;
  logic signed [WIDTH-1:0] r_sum_s1, r_sum_s2, r_sum_s3, r_sum_s4;
  logic signed [WIDTH-1:0] r_sum_t0, r_sum_t1, r_sum_t2;
  logic                    r_vld_p1;
  logic signed [WIDTH-1:0] r_s_p1, r_s2_p1, r_sy_p1, r_y_p1;
  logic signed [WIDTH-1:0] w_s3_p2, w_s4_p2, w_s2y_p2;
  logic [NW-1:0]           w_n_wide;
  logic signed [WIDTH-1:0] w_n;

  assign s_ready    = (r_state == S_ACCUM);
  assign reg_start  = (r_state == S_SOLVE);
  assign beta_valid = (r_state == S_OUTPUT);
  assign busy       = (r_state != S_IDLE);
  assign itm_count  = r_itm_count;
  assign w_take     = s_valid & s_ready;

  // Path count in Q format, clamped once the count exceeds the integer range.
  assign w_n_wide = NW'(r_itm_count) << QFRAC;
  assign w_n      = (w_n_wide > NW'(SMAX)) ? SMAX : w_n_wide[WIDTH-1:0];

  always_comb begin
    w_next        = r_state;
    w_done_hit    = 1'b0;
    w_timeout_hit = 1'b0;
    w_degen_hit   = 1'b0;
    w_enter_solve = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ACCUM;
      S_ACCUM:  if (w_take && s_last) w_next = S_DRAIN;
      S_DRAIN: begin
        // Second drain cycle: the last sample has left stage 2.
        if (r_cnt == TW'(1)) begin
          if (r_itm_count < CNT_WIDTH'(3)) begin
            w_next      = S_OUTPUT;
            w_degen_hit = 1'b1;
          end else begin
            w_next        = S_SOLVE;
            w_enter_solve = 1'b1;
          end
        end
      end
      S_SOLVE:  w_next = S_WAIT;
      S_WAIT: begin
        // A done pulse in the expiry cycle still counts as success.
        if (reg_done) begin
          w_next     = S_OUTPUT;
          w_done_hit = 1'b1;
        end else if (r_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_next        = S_OUTPUT;
          w_timeout_hit = 1'b1;
        end
      end
      S_OUTPUT: if (beta_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next)                          r_cnt <= '0;
      else if (r_state == S_DRAIN || r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Stage 1: register s, s^2, s*y, y for each accepted ITM sample.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_s_p1  <= s_price;
      r_s2_p1 <= f_mul(s_price, s_price);
      r_sy_p1 <= f_mul(s_price, s_payoff);
      r_y_p1  <= s_payoff;
    end
  end

  // Stage 2: higher powers, then saturating accumulation.
  assign w_s3_p2  = f_mul(r_s2_p1, r_s_p1);
  assign w_s4_p2  = f_mul(r_s2_p1, r_s2_p1);
  assign w_s2y_p2 = f_mul(r_s2_p1, r_y_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1    <= 1'b0;
      r_itm_count <= '0;
      r_sum_s1    <= '0;
      r_sum_s2    <= '0;
      r_sum_s3    <= '0;
      r_sum_s4    <= '0;
      r_sum_t0    <= '0;
      r_sum_t1    <= '0;
      r_sum_t2    <= '0;
    end else begin
      r_vld_p1 <= w_take & s_itm;
      if (r_state == S_IDLE && start) begin
        r_itm_count <= '0;
        r_sum_s1    <= '0;
        r_sum_s2    <= '0;
        r_sum_s3    <= '0;
        r_sum_s4    <= '0;
        r_sum_t0    <= '0;
        r_sum_t1    <= '0;
        r_sum_t2    <= '0;
      end else begin
        if (w_take && s_itm && r_itm_count != '1) r_itm_count <= r_itm_count + 1'b1;
        if (r_vld_p1) begin
          r_sum_s1 <= f_add_sat(r_sum_s1, r_s_p1);
          r_sum_s2 <= f_add_sat(r_sum_s2, r_s2_p1);
          r_sum_s3 <= f_add_sat(r_sum_s3, w_s3_p2);
          r_sum_s4 <= f_add_sat(r_sum_s4, w_s4_p2);
          r_sum_t0 <= f_add_sat(r_sum_t0, r_y_p1);
          r_sum_t1 <= f_add_sat(r_sum_t1, r_sy_p1);
          r_sum_t2 <= f_add_sat(r_sum_t2, w_s2y_p2);
        end
      end
    end
  end

  // Solver operands frozen on entering SOLVE; result captured on leaving WAIT/DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_A_flat <= '0;
      reg_B_flat <= '0;
      beta_out   <= '0;
      beta_err   <= 2'b00;
    end else begin
      if (w_enter_solve) begin
        reg_A_flat <= {r_sum_s4, r_sum_s3, r_sum_s2,
                       r_sum_s3, r_sum_s2, r_sum_s1,
                       r_sum_s2, r_sum_s1, w_n};
        reg_B_flat <= {r_sum_t2, r_sum_t1, r_sum_t0};
      end
      if (w_done_hit) begin
        beta_out <= reg_beta;
        beta_err <= 2'b00;
      end else if (w_timeout_hit) begin
        beta_out <= '0;
        beta_err <= 2'b10;
      end else if (w_degen_hit) begin
        beta_out <= '0;
        beta_err <= 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_lsm_regression_scheduler.sv
module tb_lsm_regression_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, start, s_valid, s_itm, s_last, reg_done, beta_ready;
  logic        s_ready, reg_start, beta_valid, busy;
  logic [31:0] s_price, s_payoff;
  logic [287:0] reg_A_flat;
  logic [95:0] reg_B_flat, reg_beta, beta_out;
  logic [1:0]  beta_err;
  logic [15:0] itm_count;

  int n_tests = 0;
  int n_fail  = 0;

  lsm_regression_scheduler #(.WIDTH(32), .CNT_WIDTH(16), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_price(s_price), .s_payoff(s_payoff), .s_itm(s_itm), .s_last(s_last),
    .reg_start(reg_start), .reg_A_flat(reg_A_flat), .reg_B_flat(reg_B_flat),
    .reg_done(reg_done), .reg_beta(reg_beta), .beta_valid(beta_valid),
    .beta_ready(beta_ready), .beta_out(beta_out), .beta_err(beta_err),
    .itm_count(itm_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int               nsmp;
    logic [4:0][31:0] price;
    logic [4:0][31:0] payoff;
    logic [4:0]       itm;
    logic [4:0]       gap;
    logic             degen;
    int               delay;
    int               hold;
    logic [2:0][31:0] beta;
    logic [31:0]      e_n, e_s1, e_s2, e_s3, e_s4, e_t0, e_t1, e_t2;
    logic [1:0]       e_err;
    logic [15:0]      e_itm;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic smp(input int v, input int i, input logic [31:0] p, input logic [31:0] y,
                     input logic itm, input logic gap);
    tbl[v].price[i]  = p;
    tbl[v].payoff[i] = y;
    tbl[v].itm[i]    = itm;
    tbl[v].gap[i]    = gap;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"}, 96'(busy), 96'(0));
    check({tag, " s_ready"}, 96'(s_ready), 96'(0));
    check({tag, " reg_start"}, 96'(reg_start), 96'(0));
    check({tag, " beta_valid"}, 96'(beta_valid), 96'(0));
    check({tag, " beta_out"}, beta_out, 96'(0));
    check({tag, " beta_err"}, 96'(beta_err), 96'(0));
    check({tag, " itm_count"}, 96'(itm_count), 96'(0));
    check({tag, " A_flat_or"}, 96'(|reg_A_flat), 96'(0));
    check({tag, " B_flat"}, reg_B_flat, 96'(0));
  endtask

  // Start a batch, stream samples (with a start pulse mid-batch), check drain timing.
  // Returns at the negedge two edges after the s_last handshake.
  task automatic send_batch(input int v);
    vec_t t;
    t = tbl[v];
    @(negedge clk);
    check($sformatf("v%0d idle", v), 96'(busy), 96'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d s_ready", v), 96'(s_ready), 96'(1));
    check($sformatf("v%0d itm_clr", v), 96'(itm_count), 96'(0));
    for (int i = 0; i < t.nsmp; i++) begin
      if (t.gap[i]) begin
        s_valid = 1'b0;
        s_price = 32'h1234_5678;
        @(negedge clk);
      end
      s_valid  = 1'b1;
      s_price  = t.price[i];
      s_payoff = t.payoff[i];
      s_itm    = t.itm[i];
      s_last   = (i == t.nsmp - 1);
      start    = (i == 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
    check($sformatf("v%0d drain0", v), 96'({reg_start, beta_valid, s_ready}), 96'(0));
    check($sformatf("v%0d itm_count", v), 96'(itm_count), 96'(t.e_itm));
    @(negedge clk);
    check($sformatf("v%0d drain1", v), 96'({reg_start, beta_valid}), 96'(0));
    @(negedge clk);
    if (t.degen)
      check($sformatf("v%0d degen_out", v), 96'({reg_start, beta_valid}), 96'(1));
    else
      check($sformatf("v%0d reg_start", v), 96'({reg_start, beta_valid}), 96'(2));
  endtask

  task automatic run_vec(input int v);
    vec_t t;
    logic [8:0][31:0] ea;
    logic [95:0] eb;
    t = tbl[v];
    send_batch(v);
    if (!t.degen) begin
      ea = {t.e_s4, t.e_s3, t.e_s2, t.e_s3, t.e_s2, t.e_s1, t.e_s2, t.e_s1, t.e_n};
      for (int k = 0; k < 9; k++)
        check($sformatf("v%0d A[%0d]", v, k), 96'(reg_A_flat[32*k +: 32]), 96'(ea[k]));
      check($sformatf("v%0d B", v), reg_B_flat, {t.e_t2, t.e_t1, t.e_t0});
      @(negedge clk);
      repeat (t.delay) @(negedge clk);
      reg_done = 1'b1;
      reg_beta = t.beta;
      @(negedge clk);
      reg_done = 1'b0;
      reg_beta = 96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
      check($sformatf("v%0d beta_valid", v), 96'(beta_valid), 96'(1));
    end
    eb = t.degen ? 96'(0) : t.beta;
    check($sformatf("v%0d beta_out", v), beta_out, eb);
    check($sformatf("v%0d beta_err", v), 96'(beta_err), 96'(t.e_err));
    for (int j = 0; j < t.hold; j++) begin
      start = (j % 3 == 0);
      @(negedge clk);
      check($sformatf("v%0d hold%0d", v, j), {beta_out[94:0], beta_valid}, {eb[94:0], 1'b1});
    end
    start = 1'b0;
    check($sformatf("v%0d itm_hold", v), 96'(itm_count), 96'(t.e_itm));
    beta_ready = 1'b1;
    @(negedge clk);
    beta_ready = 1'b0;
    check($sformatf("v%0d back_idle", v), 96'({busy, beta_valid}), 96'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_itm = 1'b0; s_last = 1'b0;
    reg_done = 1'b0; beta_ready = 1'b0; s_price = '0; s_payoff = '0; reg_beta = '0;

    tbl[0] = '0; tbl[0].nsmp = 4; tbl[0].delay = 5;
    smp(0, 0, 32'h0000_0000, 32'h0001_0000, 1, 0);
    smp(0, 1, 32'h0001_0000, 32'h0006_0000, 1, 0);
    smp(0, 2, 32'h0002_0000, 32'h0011_0000, 1, 0);
    smp(0, 3, 32'h0003_0000, 32'h0022_0000, 1, 0);
    tbl[0].beta = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    tbl[0].e_n = 32'h0004_0000; tbl[0].e_s1 = 32'h0006_0000; tbl[0].e_s2 = 32'h000E_0000;
    tbl[0].e_s3 = 32'h0024_0000; tbl[0].e_s4 = 32'h0062_0000;
    tbl[0].e_t0 = 32'h003A_0000; tbl[0].e_t1 = 32'h008E_0000; tbl[0].e_t2 = 32'h017C_0000;
    tbl[0].e_itm = 16'd4;

    tbl[1] = '0; tbl[1].nsmp = 5; tbl[1].degen = 1'b1;
    smp(1, 0, 32'h0001_0000, 32'h0001_0000, 1, 0);
    smp(1, 1, 32'h0002_0000, 32'h0001_0000, 0, 0);
    smp(1, 2, 32'h0003_0000, 32'h0001_0000, 1, 1);
    smp(1, 3, 32'h0004_0000, 32'h0001_0000, 0, 0);
    smp(1, 4, 32'h0005_0000, 32'h0001_0000, 0, 0);
    tbl[1].e_err = 2'b01; tbl[1].e_itm = 16'd2;

    tbl[2] = '0; tbl[2].nsmp = 4; tbl[2].delay = 2;
    for (int i = 0; i < 4; i++) smp(2, i, 32'h7FFF_0000, 32'h0000_0000, 1, (i % 2 == 1));
    tbl[2].beta = {32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000};
    tbl[2].e_n = 32'h0004_0000; tbl[2].e_s1 = 32'h7FFF_FFFF; tbl[2].e_s2 = 32'h7FFF_FFFF;
    tbl[2].e_s3 = 32'h7FFF_FFFF; tbl[2].e_s4 = 32'h7FFF_FFFF;
    tbl[2].e_itm = 16'd4;

    tbl[3] = '0; tbl[3].nsmp = 4; tbl[3].delay = 1;
    smp(3, 0, 32'hFFFF_0000, 32'h0002_0000, 1, 0);
    smp(3, 1, 32'hFFFE_0000, 32'hFFFF_0000, 1, 0);
    smp(3, 2, 32'h0000_8000, 32'h0005_0000, 0, 0);
    smp(3, 3, 32'h0001_0000, 32'h0003_0000, 1, 0);
    tbl[3].beta = {32'hFFFF_8000, 32'h0000_4000, 32'h0007_0000};
    tbl[3].e_n = 32'h0003_0000; tbl[3].e_s1 = 32'hFFFE_0000; tbl[3].e_s2 = 32'h0006_0000;
    tbl[3].e_s3 = 32'hFFF8_0000; tbl[3].e_s4 = 32'h0012_0000;
    tbl[3].e_t0 = 32'h0004_0000; tbl[3].e_t1 = 32'h0003_0000; tbl[3].e_t2 = 32'h0001_0000;
    tbl[3].e_itm = 16'd3;

    tbl[4] = '0; tbl[4].nsmp = 3; tbl[4].delay = 0; tbl[4].hold = 10;
    for (int i = 0; i < 3; i++) smp(4, i, 32'h0000_8000, 32'h0000_4000, 1, 0);
    tbl[4].beta = {32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF};
    tbl[4].e_n = 32'h0003_0000; tbl[4].e_s1 = 32'h0001_8000; tbl[4].e_s2 = 32'h0000_C000;
    tbl[4].e_s3 = 32'h0000_6000; tbl[4].e_s4 = 32'h0000_3000;
    tbl[4].e_t0 = 32'h0000_C000; tbl[4].e_t1 = 32'h0000_6000; tbl[4].e_t2 = 32'h0000_3000;
    tbl[4].e_itm = 16'd3;

    repeat (2) @(negedge clk);
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    for (int v = 0; v < 5; v++) run_vec(v);

    // Solver never answers: abort 65 cycles after the start pulse.
    send_batch(0);
    repeat (64) @(negedge clk);
    check("timeout early", 96'(beta_valid), 96'(0));
    @(negedge clk);
    check("timeout valid", 96'(beta_valid), 96'(1));
    check("timeout err", 96'(beta_err), 96'(2));
    check("timeout beta", beta_out, 96'(0));
    beta_ready = 1'b1;
    @(negedge clk);
    beta_ready = 1'b0;

    // Done arrives in the very cycle the timeout expires.
    send_batch(0);
    repeat (64) @(negedge clk);
    reg_done = 1'b1;
    reg_beta = {32'h0000_0009, 32'h0000_0008, 32'h0000_0007};
    @(negedge clk);
    reg_done = 1'b0;
    check("race valid", 96'(beta_valid), 96'(1));
    check("race err", 96'(beta_err), 96'(0));
    check("race beta", beta_out, {32'h0000_0009, 32'h0000_0008, 32'h0000_0007});
    beta_ready = 1'b1;
    @(negedge clk);
    beta_ready = 1'b0;

    // Reset while waiting on the solver, then a stale done pulse.
    send_batch(3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reg_done = 1'b1;
    reg_beta = {32'h0000_0005, 32'h0000_0005, 32'h0000_0005};
    @(negedge clk);
    reg_done = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_wait");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
